mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single line-wide memory port between the instruction cache (I) and the data cache (D). It sits between the caches' refill/writeback interfaces and the memory model and accepts one transaction at a time. Each transaction runs to completion, and its response goes back only to the owner. Arbitration is round-robin so that neither cache starves.

## Interface
- ADDR_WIDTH, 32, byte address width
- LINE_BYTES, 16, line size; data buses are LINE_BYTES*8 bits wide

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- i_req  in  1  I-cache request; held until i_gnt is seen
- i_addr  in  ADDR_WIDTH  I-cache line address; forwarded unmodified
- i_gnt  out  1  one-cycle pulse when the I request is accepted
- i_rvalid  out  1  one-cycle pulse carrying the I read line
- i_rdata  out  LINE_BYTES*8  I read line
- d_req  in  1  D-cache request
- d_we  in  1  D request is a write (line writeback)
- d_addr  in  ADDR_WIDTH  D line address
- d_wdata  in  LINE_BYTES*8  D write line
- d_gnt  out  1  one-cycle accept pulse
- d_rvalid  out  1  one-cycle pulse: read data, or write acknowledge
- d_rdata  out  LINE_BYTES*8  D read line
- mem_req  out  1  memory request, held until mem_gnt
- mem_we  out  1  write qualifier
- mem_addr  out  ADDR_WIDTH  latched address
- mem_wdata  out  LINE_BYTES*8  latched write line
- mem_gnt  in  1  memory accepted the request
- mem_rvalid  in  1  completion: read data valid, or write done
- mem_rdata  in  LINE_BYTES*8  read line

## Operation
- All outputs reset to 0.
- Reset values for internal state:
  - state = S_IDLE
  - last_owner = OWN_I, so D wins the first collision.
- S_IDLE, when any request is present:
  - Pick the owner. If only one cache requests, that cache wins. If both request, the cache that is not last_owner wins.
  - Latch the owner, the owner's address, and for D also d_we and d_wdata. For I, mem_we is 0.
  - Set last_owner to the chosen cache.
  - Pulse the owner's gnt, assert mem_req, and go to S_ISSUE.
- S_ISSUE:
  - Hold mem_req, mem_we, mem_addr and mem_wdata stable until mem_gnt is sampled high.
  - On mem_gnt, drop mem_req and go to S_WAIT.
  - If mem_rvalid is high in the same cycle as mem_gnt, complete immediately and go to S_IDLE.
- S_WAIT: on mem_rvalid, complete and go to S_IDLE.
- Completion:
  - Pulse the owner's rvalid.
  - On a read, register mem_rdata into the owner's rdata.
  - On a write ack, the owner's rdata keeps its previous value.
  - The non-owner's rvalid and rdata never change.
- Ignored inputs:
  - Requests are ignored outside S_IDLE.
  - mem_rvalid is ignored in S_IDLE, and in S_ISSUE when mem_gnt is low.
  - mem_gnt is ignored outside S_ISSUE.
- Reset mid-operation aborts the transaction with no response to either cache. Any late mem_rvalid is then dropped, because the arbiter is in S_IDLE.

## Timing
- All outputs are registered.
- Request x_req high in cycle 0 while in S_IDLE:
  - cycle 1: x_gnt=1 and mem_req=1 together; x_gnt lasts exactly one cycle.
- mem_gnt sampled in cycle k: mem_req=0 from cycle k+1.
- mem_rvalid in cycle m: x_rvalid=1 in cycle m+1, and the arbiter is in S_IDLE in cycle m+1.
- A new request sampled in cycle m+1 is granted in cycle m+2, so there is one dead cycle between transactions.
- Best case, from x_req to x_rvalid: 2 cycles plus the memory latency from mem_gnt to mem_rvalid.

## Structure
- Package mem_arb_pkg holds:
  - state_t {S_IDLE, S_ISSUE, S_WAIT}
  - owner_t {OWN_I, OWN_D}
  - line-width localparam helpers
- One sub-module is natural: mem_arb_rr. It is the 2-way round-robin picker, holding the last_owner register plus the winner logic. It takes a request vector and an accept strobe, and outputs the winner.

## Test plan
- Single I read:
  - Stimulus: i_addr=0x0000_0040; mem_gnt immediate; mem_rvalid 3 cycles later with rdata=0x00112233_44556677_8899AABB_CCDDEEFF.
  - Required: i_gnt in cycle 1; mem_addr=0x40 and mem_we=0; i_rvalid one cycle after mem_rvalid with the same line; d_rvalid stays 0.
- Collision after reset:
  - Stimulus: i_req and d_req both high in cycle 0 (D read 0x200, I read 0x40).
  - Required: D is served first (mem_addr=0x200), then I (mem_addr=0x40); exactly one gnt pulse per cache.
- Fairness:
  - Stimulus: both requests held continuously for 4 transactions.
  - Required: grant order D, I, D, I; mem_addr alternates accordingly.
- Memory stall:
  - Stimulus: mem_gnt held low for 5 cycles.
  - Required: mem_req, mem_addr and mem_wdata stay stable; no second gnt; a new i_req is ignored until completion.
- D write:
  - Stimulus: d_we=1, d_addr=0x100, d_wdata=0xA5 repeated across the line.
  - Required: mem_we=1 and mem_wdata matches; d_rvalid pulses on the ack; d_rdata is unchanged.
- Reset in S_WAIT:
  - Stimulus: assert rstn low while in S_WAIT; release; then drive mem_rvalid.
  - Required: all outputs go to 0 immediately; neither i_rvalid nor d_rvalid pulses; the next request is arbitrated with D winning ties.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the I/D memory-port arbiter.
package mem_arb_pkg;

   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_LINE_BYTES = 16;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;

   // req[0] = I-cache, req[1] = D-cache; on a tie the cache that did not win last time goes next.
   function automatic owner_t rr_pick(input logic [1:0] req, input owner_t last);
      owner_t w;
      case (req)
         2'b11:   w = (last == OWN_I) ? OWN_D : OWN_I;
         2'b10:   w = OWN_D;
         default: w = OWN_I;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: remembers the last winner and resolves ties toward the other cache.
module mem_arb_rr
   import mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic [1:0] req,
   input  logic       accept,
   output owner_t     winner
);

   owner_t last_owner_q;
   owner_t last_owner_d;

   always_comb begin
      winner       = rr_pick(req, last_owner_q);
      last_owner_d = accept ? winner : last_owner_q;
   end

   // Reset to I so that D wins the first collision.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) last_owner_q <= OWN_I;
      else       last_owner_q <= last_owner_d;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache, one transaction at a time,
// with round-robin arbitration and responses routed only to the owning cache.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LINE_BYTES = DEF_LINE_BYTES
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    i_req,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   output logic                    i_gnt,
   output logic                    i_rvalid,
   output logic [LINE_BYTES*8-1:0] i_rdata,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [LINE_BYTES*8-1:0] d_wdata,
   output logic                    d_gnt,
   output logic                    d_rvalid,
   output logic [LINE_BYTES*8-1:0] d_rdata,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [LINE_BYTES*8-1:0] mem_wdata,
   input  logic                    mem_gnt,
   input  logic                    mem_rvalid,
   input  logic [LINE_BYTES*8-1:0] mem_rdata
);

   localparam int LINE_BITS = LINE_BYTES * 8;

   state_t                state_q, state_d;
   owner_t                owner_q, owner_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [LINE_BITS-1:0]  mem_wdata_q, mem_wdata_d;
   logic                  i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
   logic                  i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
   logic [LINE_BITS-1:0]  i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
   logic                  accept;
   logic                  complete;
   owner_t                winner;

   mem_arb_rr u_rr (
      .clk    (clk),
      .rstn   (rstn),
      .req    ({d_req, i_req}),
      .accept (accept),
      .winner (winner)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_gnt_d     = 1'b0;
      d_gnt_d     = 1'b0;
      i_rvalid_d  = 1'b0;
      d_rvalid_d  = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      accept      = 1'b0;
      complete    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_req || d_req) begin
               accept    = 1'b1;
               owner_d   = winner;
               mem_req_d = 1'b1;
               state_d   = S_ISSUE;
               if (winner == OWN_D) begin
                  d_gnt_d     = 1'b1;
                  mem_addr_d  = d_addr;
                  mem_we_d    = d_we;
                  mem_wdata_d = d_wdata;
               end else begin
                  i_gnt_d     = 1'b1;
                  mem_addr_d  = i_addr;
                  mem_we_d    = 1'b0;
                  mem_wdata_d = '0;
               end
            end
         end
         S_ISSUE: begin
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               // A memory that accepts and completes in the same cycle skips S_WAIT.
               if (mem_rvalid) begin
                  complete = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  state_d  = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               complete = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Write acks pulse rvalid but leave the owner's last read line in place.
      if (complete) begin
         if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
         end else begin
            i_rvalid_d = 1'b1;
            if (!mem_we_q) i_rdata_d = mem_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_I;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_gnt_q     <= 1'b0;
         d_gnt_q     <= 1'b0;
         i_rvalid_q  <= 1'b0;
         d_rvalid_q  <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_gnt_q     <= i_gnt_d;
         d_gnt_q     <= d_gnt_d;
         i_rvalid_q  <= i_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign i_gnt     = i_gnt_q;
   assign d_gnt     = d_gnt_q;
   assign i_rvalid  = i_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant and response scoreboards checked from a negedge monitor.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic         clk = 1'b0;
   logic         rstn;
   logic         i_req, d_req, d_we;
   logic [31:0]  i_addr, d_addr, mem_addr;
   logic [127:0] d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
   logic         i_gnt, i_rvalid, d_gnt, d_rvalid;
   logic         mem_req, mem_we, mem_gnt, mem_rvalid;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic         d;
      logic [31:0]  addr;
      logic         we;
      logic [127:0] data;
   } exp_t;

   exp_t gnt_sb[$];
   exp_t rsp_sb[$];
   logic [127:0] i_line_m = '0;
   logic [127:0] d_line_m = '0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk        (clk),
      .rstn       (rstn),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_gnt      (i_gnt),
      .i_rvalid   (i_rvalid),
      .i_rdata    (i_rdata),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_gnt      (d_gnt),
      .d_rvalid   (d_rvalid),
      .d_rdata    (d_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_gnt(input logic d, input logic [31:0] a, input logic we, input logic [127:0] wd);
      exp_t e;
      e.d = d; e.addr = a; e.we = we; e.data = wd;
      gnt_sb.push_back(e);
   endtask

   task automatic push_rsp(input logic d, input logic we, input logic [127:0] rd);
      exp_t e;
      e.d = d; e.addr = '0; e.we = we; e.data = rd;
      rsp_sb.push_back(e);
   endtask

   task automatic wait_gnt(input string tag, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(i_gnt || d_gnt) && n < 20);
      chk({tag, "_gnt_seen"}, {127'b0, i_gnt | d_gnt}, 128'd1);
   endtask

   // Memory side of one transaction, entered in the cycle the grant is visible.
   task automatic do_mem(input string tag, input int stall, input int lat, input logic [127:0] rd,
                         input logic [31:0] a, input logic we, input logic [127:0] wd);
      for (int s = 0; s < stall; s++) begin
         tick();
         chk({tag, "_stall_req"}, {127'b0, mem_req}, 128'd1);
         chk({tag, "_stall_addr"}, {96'b0, mem_addr}, {96'b0, a});
         chk({tag, "_stall_we"}, {127'b0, mem_we}, {127'b0, we});
         if (we) chk({tag, "_stall_wdata"}, mem_wdata, wd);
         chk({tag, "_stall_nognt"}, {127'b0, i_gnt | d_gnt}, 128'd0);
      end
      mem_gnt    = 1'b1;
      mem_rvalid = (lat == 0);
      mem_rdata  = rd;
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      chk({tag, "_req_dropped"}, {127'b0, mem_req}, 128'd0);
      if (lat > 0) begin
         repeat (lat - 1) tick();
         mem_rvalid = 1'b1;
         tick();
         mem_rvalid = 1'b0;
      end
      chk({tag, "_rvalid_pulse"}, {127'b0, i_rvalid | d_rvalid}, 128'd1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_i_gnt"}, {127'b0, i_gnt}, 128'd0);
      chk({tag, "_i_rvalid"}, {127'b0, i_rvalid}, 128'd0);
      chk({tag, "_i_rdata"}, i_rdata, 128'd0);
      chk({tag, "_d_gnt"}, {127'b0, d_gnt}, 128'd0);
      chk({tag, "_d_rvalid"}, {127'b0, d_rvalid}, 128'd0);
      chk({tag, "_d_rdata"}, d_rdata, 128'd0);
      chk({tag, "_mem_req"}, {127'b0, mem_req}, 128'd0);
      chk({tag, "_mem_we"}, {127'b0, mem_we}, 128'd0);
      chk({tag, "_mem_addr"}, {96'b0, mem_addr}, 128'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 128'd0);
   endtask

   // Monitor: every grant and every response must match the head of its scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (rstn === 1'b1) begin
         if (i_gnt || d_gnt) begin
            chk("gnt_onehot", {127'b0, i_gnt & d_gnt}, 128'd0);
            if (gnt_sb.size() == 0) begin
               checks++; errors++;
               $error("FAIL gnt_unexpected observed i_gnt=%0b d_gnt=%0b expected none", i_gnt, d_gnt);
            end else begin
               e = gnt_sb.pop_front();
               chk("gnt_owner", {127'b0, d_gnt}, {127'b0, e.d});
               chk("gnt_mem_req", {127'b0, mem_req}, 128'd1);
               chk("gnt_mem_addr", {96'b0, mem_addr}, {96'b0, e.addr});
               chk("gnt_mem_we", {127'b0, mem_we}, {127'b0, e.we});
               if (e.we) chk("gnt_mem_wdata", mem_wdata, e.data);
            end
         end
         if (i_rvalid || d_rvalid) begin
            chk("rvalid_onehot", {127'b0, i_rvalid & d_rvalid}, 128'd0);
            if (rsp_sb.size() == 0) begin
               checks++; errors++;
               $error("FAIL rsp_unexpected observed i_rvalid=%0b d_rvalid=%0b expected none", i_rvalid, d_rvalid);
            end else begin
               e = rsp_sb.pop_front();
               chk("rsp_owner", {127'b0, d_rvalid}, {127'b0, e.d});
               if (!e.we) begin
                  if (e.d) d_line_m = e.data;
                  else     i_line_m = e.data;
               end
               chk("rsp_i_rdata", i_rdata, i_line_m);
               chk("rsp_d_rdata", d_rdata, d_line_m);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      logic [127:0] rd0, rd1, a5_line, wline;

      rstn = 1'b0; i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
      repeat (2) tick();
      check_all_zero("reset");
      rstn = 1'b1;
      tick();

      // Single I read, immediate mem_gnt, rvalid three cycles later.
      rd0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      i_req = 1; i_addr = 32'h0000_0040;
      push_gnt(1'b0, 32'h40, 1'b0, '0);
      push_rsp(1'b0, 1'b0, rd0);
      wait_gnt("i_read", n);
      chk("i_read_gnt_cycle1", n, 128'd1);
      chk("i_read_mem_req", {127'b0, mem_req}, 128'd1);
      i_req = 0;
      do_mem("i_read", 0, 3, rd0, 32'h40, 1'b0, '0);
      chk("i_read_rdata", i_rdata, rd0);
      chk("i_read_no_d_rvalid", {127'b0, d_rvalid}, 128'd0);
      tick();
      chk("i_rvalid_one_cycle", {127'b0, i_rvalid}, 128'd0);

      // Collision right after reset: D wins first.
      rstn = 1'b0; i_line_m = '0; d_line_m = '0;
      tick();
      rstn = 1'b1;
      tick();
      rd0 = {4{32'hD00D_0200}}; rd1 = {4{32'h1CAC_0040}};
      d_req = 1; d_addr = 32'h200; i_req = 1; i_addr = 32'h40;
      push_gnt(1'b1, 32'h200, 1'b0, '0); push_rsp(1'b1, 1'b0, rd0);
      push_gnt(1'b0, 32'h40, 1'b0, '0);  push_rsp(1'b0, 1'b0, rd1);
      wait_gnt("coll_d", n);
      d_req = 0;
      do_mem("coll_d", 0, 1, rd0, 32'h200, 1'b0, '0);
      wait_gnt("coll_i", n);
      i_req = 0;
      do_mem("coll_i", 0, 2, rd1, 32'h40, 1'b0, '0);

      // Fairness: both held for four transactions -> D, I, D, I.
      d_req = 1; d_addr = 32'h1000; i_req = 1; i_addr = 32'h2000;
      push_gnt(1'b1, 32'h1000, 1'b0, '0); push_gnt(1'b0, 32'h2000, 1'b0, '0);
      push_gnt(1'b1, 32'h1040, 1'b0, '0); push_gnt(1'b0, 32'h2040, 1'b0, '0);
      for (int t = 0; t < 4; t++) begin
         rd0 = {$urandom, $urandom, $urandom, $urandom};
         push_rsp(t[0] == 1'b0, 1'b0, rd0);
         wait_gnt("fair", n);
         chk("fair_d_gnt_order", {127'b0, d_gnt}, {127'b0, t[0] == 1'b0});
         if (d_gnt) d_addr = 32'h1040;
         else       i_addr = 32'h2040;
         do_mem("fair", 0, 1 + t, rd0, d_gnt ? 32'h0 : 32'h0, 1'b0, '0);
      end
      i_req = 0; d_req = 0;

      // Memory stall on a D write; a new I request waits until completion.
      wline = {4{32'hCAFE_F00D}};
      rd1 = {4{32'h0BAD_C0DE}};
      d_req = 1; d_we = 1; d_addr = 32'h180; d_wdata = wline;
      push_gnt(1'b1, 32'h180, 1'b1, wline); push_rsp(1'b1, 1'b1, '0);
      wait_gnt("stall", n);
      d_req = 0; d_we = 0;
      i_req = 1; i_addr = 32'hC0;
      push_gnt(1'b0, 32'hC0, 1'b0, '0); push_rsp(1'b0, 1'b0, rd1);
      do_mem("stall", 5, 2, 128'hDEAD, 32'h180, 1'b1, wline);
      chk("stall_d_rdata_kept", d_rdata, d_line_m);
      wait_gnt("stall_i", n);
      chk("stall_i_after_dead_cycle", n, 128'd1);
      i_req = 0;
      do_mem("stall_i", 0, 0, rd1, 32'hC0, 1'b0, '0);

      // D write with A5 pattern.
      a5_line = {16{8'hA5}};
      d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = a5_line;
      push_gnt(1'b1, 32'h100, 1'b1, a5_line); push_rsp(1'b1, 1'b1, '0);
      wait_gnt("d_write", n);
      d_req = 0; d_we = 0;
      do_mem("d_write", 0, 2, 128'h5555, 32'h100, 1'b1, a5_line);
      chk("d_write_rdata_kept", d_rdata, d_line_m);

      // Reset while waiting for memory: no response, late rvalid dropped.
      d_req = 1; d_addr = 32'h300;
      push_gnt(1'b1, 32'h300, 1'b0, '0);
      wait_gnt("rst_wait", n);
      d_req = 0;
      mem_gnt = 1;
      tick();
      mem_gnt = 0;
      tick();
      rstn = 1'b0;
      #1;
      check_all_zero("rst_async");
      i_line_m = '0; d_line_m = '0;
      tick();
      rstn = 1'b1;
      tick();
      mem_rvalid = 1; mem_rdata = {4{32'hBAD0_BAD0}};
      tick();
      mem_rvalid = 0;
      chk("rst_late_i_rvalid", {127'b0, i_rvalid}, 128'd0);
      chk("rst_late_d_rvalid", {127'b0, d_rvalid}, 128'd0);
      tick();

      rd0 = {4{32'h3400_3400}}; rd1 = {4{32'h3800_3800}};
      d_req = 1; d_addr = 32'h340; i_req = 1; i_addr = 32'h380;
      push_gnt(1'b1, 32'h340, 1'b0, '0); push_rsp(1'b1, 1'b0, rd0);
      push_gnt(1'b0, 32'h380, 1'b0, '0); push_rsp(1'b0, 1'b0, rd1);
      wait_gnt("post_rst_d", n);
      d_req = 0;
      do_mem("post_rst_d", 1, 1, rd0, 32'h340, 1'b0, '0);
      wait_gnt("post_rst_i", n);
      i_req = 0;
      do_mem("post_rst_i", 0, 1, rd1, 32'h380, 1'b0, '0);
      repeat (3) tick();

      chk("gnt_sb_empty", gnt_sb.size(), 128'd0);
      chk("rsp_sb_empty", rsp_sb.size(), 128'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
